// File: rtl/phc_debounce_pkg.sv
// Shared types and default parameters for the photocell debouncer.
package phc_debounce_pkg;

  // Per-channel debounce FSM encoding.
  typedef enum logic [1:0] {
    StStableHigh = 2'd0,
    StCheckLow   = 2'd1,
    StStableLow  = 2'd2,
    StCheckHigh  = 2'd3
  } phc_state_e;

  localparam int unsigned DebounceCyclesDef = 4;
  localparam int unsigned StuckCyclesDef    = 1000;

endpackage

// File: rtl/phc_channel.sv
// One photocell channel: synchronizer, debounce FSM, fall strobe and stuck-beam detection.
module phc_channel
  import phc_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDef,
  parameter int unsigned STUCK_CYCLES    = StuckCyclesDef
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic fall_pulse,
  output logic stuck
);

  localparam int unsigned DebW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned StkW = $clog2(STUCK_CYCLES + 1);
  // The sample that moves count from D-1 to D completes the debounce.
  localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [StkW-1:0] StkMax  = StkW'(STUCK_CYCLES);
  localparam bit SingleSample = (DEBOUNCE_CYCLES == 1);

  logic sync1_q, sync2_q;
  logic samp;

  phc_state_e state_q, state_d;
  logic [DebW-1:0] cnt_q, cnt_d;
  logic clean_q, clean_d;
  logic pulse_q, pulse_d;
  logic [StkW-1:0] stk_q, stk_d;
  logic stuck_q, stuck_d;

  // Two-flop synchronizer; resets to the idle (beam clear) level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign samp = sync2_q;

  // Debounce next-state: a run of samples opposite the clean level must reach
  // DEBOUNCE_CYCLES; any sample matching the clean level drops the pending change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    pulse_d = 1'b0;
    unique case (state_q)
      StStableHigh: begin
        if (!samp) begin
          if (SingleSample) begin
            state_d = StStableLow;
            clean_d = 1'b0;
            pulse_d = 1'b1;
          end else begin
            state_d = StCheckLow;
            cnt_d   = DebW'(1);
          end
        end
      end
      StCheckLow: begin
        if (samp) begin
          state_d = StStableHigh;
          cnt_d   = '0;
        end else if (cnt_q >= DebLast) begin
          state_d = StStableLow;
          cnt_d   = '0;
          clean_d = 1'b0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DebW'(1);
        end
      end
      StStableLow: begin
        if (samp) begin
          if (SingleSample) begin
            state_d = StStableHigh;
            clean_d = 1'b1;
          end else begin
            state_d = StCheckHigh;
            cnt_d   = DebW'(1);
          end
        end
      end
      StCheckHigh: begin
        if (!samp) begin
          state_d = StStableLow;
          cnt_d   = '0;
        end else if (cnt_q >= DebLast) begin
          state_d = StStableHigh;
          cnt_d   = '0;
          clean_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DebW'(1);
        end
      end
    endcase
  end

  // Stuck detection: count cycles spent with clean low, saturating; a return to
  // high clears both the counter and the flag on that same edge.
  always_comb begin
    stk_d = stk_q;
    if (clean_d) begin
      stk_d = '0;
    end else if (!clean_q && (stk_q != StkMax)) begin
      stk_d = stk_q + StkW'(1);
    end
    stuck_d = (stk_d == StkMax);
  end

  // State, counter and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StStableHigh;
      cnt_q   <= '0;
      clean_q <= 1'b1;
      pulse_q <= 1'b0;
      stk_q   <= '0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      pulse_q <= pulse_d;
      stk_q   <= stk_d;
      stuck_q <= stuck_d;
    end
  end

  assign clean      = clean_q;
  assign fall_pulse = pulse_q;
  assign stuck      = stuck_q;

endmodule

// File: rtl/phc_debounce.sv
// Entry/exit photocell conditioner: two independent debounced channels.
module phc_debounce
  import phc_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDef,
  parameter int unsigned STUCK_CYCLES    = StuckCyclesDef
) (
  input  logic clock,
  input  logic reset,
  input  logic phcOne_raw,
  input  logic phcTwo_raw,
  output logic phcOne,
  output logic phcTwo,
  output logic enterPulse,
  output logic leavePulse,
  output logic stuckOne,
  output logic stuckTwo
);

  phc_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_one (
    .clock     (clock),
    .reset     (reset),
    .raw       (phcOne_raw),
    .clean     (phcOne),
    .fall_pulse(enterPulse),
    .stuck     (stuckOne)
  );

  phc_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_two (
    .clock     (clock),
    .reset     (reset),
    .raw       (phcTwo_raw),
    .clean     (phcTwo),
    .fall_pulse(leavePulse),
    .stuck     (stuckTwo)
  );

endmodule

// File: tb/tb_phc_debounce.sv
// Self-checking bench for phc_debounce: directed scenarios plus random toggling,
// checked every cycle against a window-based reference model.
module tb_phc_debounce;

  localparam int DEB = 4;
  localparam int STK = 20;

  logic clock = 1'b0;
  logic reset;
  logic phcOne_raw, phcTwo_raw;
  logic phcOne, phcTwo, enterPulse, leavePulse, stuckOne, stuckTwo;

  int total  = 0;
  int passed = 0;
  int n_enter = 0;
  int n_leave = 0;

  // Reference model state per channel (0 = One, 1 = Two).
  logic m_s1[2], m_s2[2], m_clean[2], m_pulse[2], m_stuck[2];
  int   m_low[2];
  logic m_win[2][DEB];

  phc_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .STUCK_CYCLES   (STK)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .phcOne_raw(phcOne_raw),
    .phcTwo_raw(phcTwo_raw),
    .phcOne    (phcOne),
    .phcTwo    (phcTwo),
    .enterPulse(enterPulse),
    .leavePulse(leavePulse),
    .stuckOne  (stuckOne),
    .stuckTwo  (stuckTwo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0b expected %0b", tag, got, exp);
  endtask

  // Model: clean flips once the last DEB synchronized samples all differ from it.
  task automatic model_edge(input logic rst, input logic r0, input logic r1);
    logic raws[2];
    logic samp, old, allopp;
    raws[0] = r0;
    raws[1] = r1;
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        m_s1[c] = 1'b1; m_s2[c] = 1'b1; m_clean[c] = 1'b1;
        m_pulse[c] = 1'b0; m_stuck[c] = 1'b0; m_low[c] = 0;
        for (int i = 0; i < DEB; i++) m_win[c][i] = 1'b1;
      end else begin
        samp = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = raws[c];
        for (int i = DEB - 1; i > 0; i--) m_win[c][i] = m_win[c][i-1];
        m_win[c][0] = samp;
        allopp = 1'b1;
        for (int i = 0; i < DEB; i++) if (m_win[c][i] == m_clean[c]) allopp = 1'b0;
        old = m_clean[c];
        if (allopp) m_clean[c] = ~old;
        m_pulse[c] = old & ~m_clean[c];
        if (m_clean[c]) begin
          m_low[c] = 0;
          m_stuck[c] = 1'b0;
        end else if (!old) begin
          if (m_low[c] < STK) m_low[c]++;
          m_stuck[c] = (m_low[c] == STK);
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic tick(input logic rst, input logic r1, input logic r2);
    reset = rst;
    phcOne_raw = r1;
    phcTwo_raw = r2;
    @(posedge clock);
    model_edge(rst, r1, r2);
    #1;
    if (enterPulse === 1'b1) n_enter++;
    if (leavePulse === 1'b1) n_leave++;
    chk("model_phcOne", phcOne, m_clean[0]);
    chk("model_phcTwo", phcTwo, m_clean[1]);
    chk("model_enterPulse", enterPulse, m_pulse[0]);
    chk("model_leavePulse", leavePulse, m_pulse[1]);
    chk("model_stuckOne", stuckOne, m_stuck[0]);
    chk("model_stuckTwo", stuckTwo, m_stuck[1]);
  endtask

  initial begin
    logic r1, r2;
    // Reset state.
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    chk("reset_phcOne", phcOne, 1'b1);
    chk("reset_phcTwo", phcTwo, 1'b1);
    chk("reset_pulses", enterPulse | leavePulse, 1'b0);
    chk("reset_stuck", stuckOne | stuckTwo, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1);

    // Clean press: raw first sampled at edge 0, clean falls after edge 5.
    tick(1'b0, 1'b0, 1'b1);
    for (int e = 1; e <= 6; e++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (e < 5) chk("press_not_yet", phcOne, 1'b1);
      if (e == 5) begin
        chk("press_fall", phcOne, 1'b0);
        chk("press_pulse", enterPulse, 1'b1);
      end
      if (e == 6) chk("press_pulse_one_cycle", enterPulse, 1'b0);
    end
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b1);
    chk("press_release", phcOne, 1'b1);

    // Glitch rejection on channel Two.
    for (int rep = 0; rep < 5; rep++) begin
      for (int i = 0; i < 5; i++) begin
        tick(1'b0, 1'b1, (i < 3) ? 1'b0 : 1'b1);
        chk("glitch_clean", phcTwo, 1'b1);
        chk("glitch_no_pulse", leavePulse, 1'b0);
      end
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1);

    // Simultaneous fall on both channels, then hold One (and Two) low for stuck.
    for (int e = 0; e <= 5; e++) tick(1'b0, 1'b0, 1'b0);
    chk("simul_enter", enterPulse, 1'b1);
    chk("simul_leave", leavePulse, 1'b1);
    for (int e = 1; e <= 20; e++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (e < 20) chk("stuck_not_yet", stuckOne, 1'b0);
      else chk("stuck_set", stuckOne, 1'b1);
    end
    for (int e = 0; e <= 5; e++) begin
      tick(1'b0, 1'b1, 1'b1);
      if (e < 5) chk("stuck_held", stuckOne, 1'b1);
      else begin
        chk("stuck_release_clean", phcOne, 1'b1);
        chk("stuck_clear", stuckOne, 1'b0);
        chk("stuck_release_no_pulse", enterPulse, 1'b0);
      end
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1);

    // Reset at count 3 of 4, raw kept low across and after reset.
    for (int e = 0; e <= 4; e++) tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    chk("rst_mid_clean", phcOne, 1'b1);
    chk("rst_mid_no_pulse", enterPulse, 1'b0);
    for (int e = 1; e <= 6; e++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (e < 6) chk("rst_redebounce_wait", phcOne, 1'b1);
      else begin
        chk("rst_redebounce_fall", phcOne, 1'b0);
        chk("rst_redebounce_pulse", enterPulse, 1'b1);
      end
    end
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b1);

    // Chain: three entries then one exit leaves two in the queue.
    n_enter = 0;
    n_leave = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b1);
    end
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 1'b1);
    chk("chain_pcount_is_2", ((n_enter - n_leave) == 2), 1'b1);

    // Random toggling with occasional reset; the model checks every cycle.
    r1 = 1'b1;
    r2 = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 4) == 0) r1 = ~r1;
      if ($urandom_range(0, 4) == 0) r2 = ~r2;
      if (i >= 300 && i < 340) r1 = 1'b0;
      tick(($urandom_range(0, 59) == 0), r1, r2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
